// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Loads a counted little-endian byte stream into instruction RAM
//            and holds the CPU core in reset until the load completes.
// Revision : 1.0
// ============================================================================
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_CNT_LO = 3'd0;
    localparam logic [2:0] S_CNT_HI = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_ERR    = 3'd4;

    localparam logic [16:0]     c_depth = 17'(1) << ADDR_W;
    localparam logic [ADDR_W:0] c_one   = (ADDR_W+1)'(1);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [7:0]        r_cnt_lo;
    logic [ADDR_W:0]   r_word_idx;
    logic [ADDR_W:0]   r_last_idx;
    logic [1:0]        r_byte_idx;
    logic [23:0]       r_word;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_wdata;

    logic        w_accept;
    logic [15:0] w_n;
    logic        w_last;

    assign w_accept = in_valid & in_ready;
    assign w_n      = {in_data, r_cnt_lo};
    assign w_last   = (r_word_idx == r_last_idx);

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_state <= S_CNT_LO;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CNT_LO: if (w_accept) w_next = S_CNT_HI;
            S_CNT_HI: begin
                if (w_accept) begin
                    if (w_n == 16'd0)                 w_next = S_DONE;
                    else if ({1'b0, w_n} > c_depth)   w_next = S_ERR;
                    else                              w_next = S_DATA;
                end
            end
            S_DATA:   if (w_accept && (r_byte_idx == 2'd3) && w_last) w_next = S_DONE;
            S_DONE:   if (reload) w_next = S_CNT_LO;
            S_ERR:    if (reload) w_next = S_CNT_LO;
            default:  w_next = S_CNT_LO;
        endcase
    end

    always_comb begin
        in_ready = (r_state == S_CNT_LO) || (r_state == S_CNT_HI) || (r_state == S_DATA);
        done     = (r_state == S_DONE);
        err      = (r_state == S_ERR);
        core_rst = (r_state != S_DONE);
    end

    // Lane 3 bypasses the assembly register so the next word can start immediately.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_cnt_lo   <= '0;
            r_word_idx <= '0;
            r_last_idx <= '0;
            r_byte_idx <= '0;
            r_word     <= '0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    S_CNT_LO: r_cnt_lo <= in_data;
                    S_CNT_HI: begin
                        r_word_idx <= '0;
                        r_byte_idx <= '0;
                        r_last_idx <= w_n[ADDR_W:0] - c_one;
                    end
                    S_DATA: begin
                        case (r_byte_idx)
                            2'd0: r_word[7:0]   <= in_data;
                            2'd1: r_word[15:8]  <= in_data;
                            2'd2: r_word[23:16] <= in_data;
                            default: begin
                                r_we       <= 1'b1;
                                r_waddr    <= r_word_idx[ADDR_W-1:0];
                                r_wdata    <= {in_data, r_word};
                                r_word_idx <= r_word_idx + c_one;
                            end
                        endcase
                        r_byte_idx <= r_byte_idx + 2'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign imem_we    = r_we;
    assign imem_waddr = r_waddr;
    assign imem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Directed scoreboard bench for imem_loader.
// Revision : 1.0
// ============================================================================
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rstn = 1'b1;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              reload = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              done;
    logic              err;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_writes = 0;
    int          w_before;
    logic [40:0] exp_q[$];
    logic [40:0] m_e;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard entry: {last word, address, data}
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {63'd0, imem_we}, 64'd0);
            end else begin
                m_e = exp_q.pop_front();
                chk("waddr", {56'd0, imem_waddr}, {56'd0, m_e[39:32]});
                chk("wdata", {32'd0, imem_wdata}, {32'd0, m_e[31:0]});
                chk("done_on_we", {63'd0, done}, {63'd0, m_e[40]});
                chk("core_rst_on_we", {63'd0, core_rst}, {63'd0, ~m_e[40]});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic send_count(input logic [15:0] n);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    task automatic push_word(input logic [7:0] a, input logic [31:0] d, input logic last);
        exp_q.push_back({last, a, d});
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        chk({tag, "_core_rst"}, {63'd0, core_rst}, 64'd1);
        chk({tag, "_we"},       {63'd0, imem_we},  64'd0);
        chk({tag, "_done"},     {63'd0, done},     64'd0);
        chk({tag, "_err"},      {63'd0, err},      64'd0);
        chk({tag, "_waddr"},    {56'd0, imem_waddr}, 64'd0);
        chk({tag, "_wdata"},    {32'd0, imem_wdata}, 64'd0);
    endtask

    task automatic check_drained(input string tag);
        idle(3);
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        // Reset state
        idle(2);
        check_reset_outputs("reset");
        rstn = 1'b0;

        // Two-word stream at full rate
        push_word(8'h00, 32'h00000293, 1'b0);
        push_word(8'h01, 32'h00000313, 1'b1);
        send_count(16'd2);
        send_word(32'h00000293, 0);
        send_word(32'h00000313, 0);
        check_drained("two_word_drain");
        chk("two_word_done", {63'd0, done}, 64'd1);
        chk("two_word_core_rst", {63'd0, core_rst}, 64'd0);
        chk("done_in_ready", {63'd0, in_ready}, 64'd0);

        // Asynchronous reset from DONE, no clock edge needed
        #2;
        rstn = 1'b1;
        #1;
        chk("async_done", {63'd0, done}, 64'd0);
        chk("async_core_rst", {63'd0, core_rst}, 64'd1);
        chk("async_waddr", {56'd0, imem_waddr}, 64'd0);
        chk("async_wdata", {32'd0, imem_wdata}, 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b0;

        // Zero count reaches DONE two cycles after reset release
        w_before = n_writes;
        send_count(16'd0);
        chk("zero_done", {63'd0, done}, 64'd1);
        chk("zero_core_rst", {63'd0, core_rst}, 64'd0);
        idle(2);
        chk("zero_writes", 64'(n_writes - w_before), 64'd0);
        pulse_reload();
        chk("zero_reload_done", {63'd0, done}, 64'd0);
        chk("zero_reload_core_rst", {63'd0, core_rst}, 64'd1);
        chk("zero_reload_ready", {63'd0, in_ready}, 64'd1);

        // Count beyond depth
        w_before = n_writes;
        send_count(16'd257);
        chk("ovf_err", {63'd0, err}, 64'd1);
        chk("ovf_ready", {63'd0, in_ready}, 64'd0);
        chk("ovf_done", {63'd0, done}, 64'd0);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        idle(4);
        in_valid = 1'b0;
        chk("ovf_sticky", {63'd0, err}, 64'd1);
        chk("ovf_writes", 64'(n_writes - w_before), 64'd0);
        pulse_reload();
        chk("ovf_reload_err", {63'd0, err}, 64'd0);
        chk("ovf_reload_ready", {63'd0, in_ready}, 64'd1);

        // Full-depth load
        w_before = n_writes;
        for (int k = 0; k < 256; k++)
            push_word(8'(k), {8'(k), ~8'(k), 8'h3C, 8'(k)}, k == 255);
        send_count(16'd256);
        for (int k = 0; k < 256; k++)
            send_word({8'(k), ~8'(k), 8'h3C, 8'(k)}, 0);
        check_drained("full_drain");
        chk("full_writes", 64'(n_writes - w_before), 64'd256);
        chk("full_done", {63'd0, done}, 64'd1);
        chk("full_last_addr", {56'd0, imem_waddr}, 64'hFF);
        pulse_reload();

        // Gapped single word
        w_before = n_writes;
        push_word(8'h00, 32'hFFFFF3B7, 1'b1);
        send_count(16'd1);
        send_word(32'hFFFFF3B7, 3);
        check_drained("gap_drain");
        chk("gap_writes", 64'(n_writes - w_before), 64'd1);
        pulse_reload();

        // Reset mid-word abandons the partial word
        w_before = n_writes;
        send_count(16'd1);
        send_byte(8'h77);
        send_byte(8'h66);
        rstn = 1'b1;
        #2;
        check_reset_outputs("midword_reset");
        @(posedge clk);
        #1;
        rstn = 1'b0;
        idle(2);
        chk("midword_no_write", 64'(n_writes - w_before), 64'd0);
        push_word(8'h00, 32'h00000013, 1'b1);
        send_count(16'd1);
        send_word(32'h00000013, 0);
        check_drained("restart_drain");
        chk("restart_writes", 64'(n_writes - w_before), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, gives the instruction RAM word-address width (depth 2^ADDR_W words).
REQ-002 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-003 rstn  input  1  is the asynchronous, active-high reset (despite the name, 1 = reset).
REQ-004 in_data  input  8  carries the loader byte stream.
REQ-005 in_valid  input  1  means in_data is valid this cycle.
REQ-006 in_ready  output  1  means the loader accepts in_data; a byte transfers when in_valid & in_ready on a rising edge.
REQ-007 reload  input  1  requests a new load; it is sampled only in DONE and ERR.
REQ-008 imem_we  output  1  is the instruction RAM write strobe, one cycle per word.
REQ-009 imem_waddr  output  ADDR_W  is the RAM word address.
REQ-010 imem_wdata  output  32  is the RAM write data.
REQ-011 core_rst  output  1  holds the CPU core in reset, active-high.
REQ-012 done  output  1  is a level meaning the load completed successfully.
REQ-013 err  output  1  is a level meaning the word count exceeded the RAM depth.

Function
REQ-014 Stream format: byte0 = count[7:0], byte1 = count[15:8] (N words), then 4N instruction bytes, each word little-endian (first byte = instr[7:0]).
REQ-015 States: CNT_LO, CNT_HI, DATA, DONE, ERR.
REQ-016 CNT_LO: accepted byte goes to count[7:0] -> CNT_HI.
REQ-017 CNT_HI: accepted byte completes N.
  - N == 0 -> DONE.
  - N > 2^ADDR_W -> ERR.
  - otherwise -> DATA with word index 0 and byte index 0.
REQ-018 in_ready is 1 in CNT_LO, CNT_HI and DATA, and 0 in DONE and ERR.
REQ-019 DATA: each accepted byte is placed in the assembly register at lane byte_idx; byte_idx wraps 3 -> 0.
REQ-020 Word write timing: on acceptance of lane 3, the next cycle drives imem_we = 1 for exactly one cycle, with imem_waddr = word index and imem_wdata = the assembled 32-bit word. All three are registered outputs.
REQ-021 The loader accepts one byte per cycle without stalls; the first byte of word k+1 may be accepted in the same cycle as word k's imem_we pulse without corrupting it.
REQ-022 After the write of word N-1 is launched, the state goes to DONE, so done rises in the same cycle as the final imem_we.
REQ-023 Word index width is ADDR_W+1, so N = 2^ADDR_W is legal. The last address is 2^ADDR_W-1 and no address wrap occurs.
REQ-024 If in_valid is 0, the loader holds all state (any gap length is allowed mid-word).
REQ-025 core_rst is 1 in all states except DONE; it falls on the cycle done rises.
REQ-026 DONE + reload = 1 -> CNT_LO next cycle, with done cleared and core_rst set. RAM contents are not cleared.
REQ-027 ERR + reload = 1 -> CNT_LO next cycle, with err cleared.
REQ-028 err is sticky in ERR otherwise; no RAM write occurs on the error path.
REQ-029 imem_we is never asserted outside DATA-completion cycles.

Reset
REQ-030 While rstn = 1, all outputs take their reset values immediately (asynchronously):
  - state = CNT_LO, in_ready = 1, core_rst = 1;
  - imem_we = 0, done = 0, err = 0;
  - imem_waddr = 0, imem_wdata = 0;
  - byte and word indices = 0.
REQ-031 Reset asserted mid-word or mid-stream abandons the partial word with no write; loading restarts from count byte0 after reset release.
REQ-032 in_ready is ignored while rstn = 1; no byte is accepted.

Verification
REQ-033 Stream 02 00 93 02 00 00 13 03 00 00 at full rate -> imem_we pulses twice:
  - addr 0, data 00000293;
  - addr 1, data 00000313;
  - done = 1 and core_rst = 0 on the second pulse cycle.
REQ-034 Count 00 00 -> DONE two cycles after reset release with zero writes; then reload = 1 -> CNT_LO, core_rst = 1, done = 0.
REQ-035 ADDR_W = 8, count 01 01 (257) -> err = 1, in_ready = 0, no imem_we.
REQ-036 ADDR_W = 8, count 00 01 (256) -> 256 writes with last addr FF, then done.
REQ-037 Word B7 F3 FF FF with in_valid deasserted 3 cycles between each byte -> single write of FFFFF3B7, no early strobe.
REQ-038 rstn pulsed after 2 data bytes -> no write; a subsequent full stream of 1 word (13 00 00 00) writes 00000013 at addr 0.
